// File: rtl/brush_stamper_if.sv
// brush_stamper_if -- request/write bus of the brush stamper.
//   master : drives req, clear_req, cx, cy, radius, color; sees ready,
//            brush, wx, wy, newColor, done.
//   slave  : the stamper itself (mirror directions).
interface brush_stamper_if;
    logic       req;
    logic       clear_req;
    logic [9:0] cx;
    logic [9:0] cy;
    logic [1:0] radius;
    logic [2:0] color;
    logic       ready;
    logic       brush;
    logic [9:0] wx;
    logic [9:0] wy;
    logic [2:0] newColor;
    logic       done;

    modport master (
        output req, clear_req, cx, cy, radius, color,
        input  ready, brush, wx, wy, newColor, done
    );

    modport slave (
        input  req, clear_req, cx, cy, radius, color,
        output ready, brush, wx, wy, newColor, done
    );
endinterface

// File: rtl/brush_stamper.sv
// brush_stamper -- paints a (2r+1)x(2r+1) square brush centred on (cx,cy),
// or sweeps the whole canvas with CLEAR_COLOR, one pixel write per cycle.
// Off-canvas pixels still take their cycle but raise no write strobe.
//   clk      : clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : slave side of brush_stamper_if
//              in : req, clear_req, cx, cy, radius, color
//              out: ready (IDLE only), brush/wx/wy/newColor (registered
//                   pixel write), done (one-cycle end-of-operation pulse)
module brush_stamper #(
    parameter int       CANVAS_W    = 10,
    parameter int       CANVAS_H    = 10,
    parameter logic [2:0] CLEAR_COLOR = 3'b000
) (
    input  logic              clk,
    input  logic              reset_n,
    brush_stamper_if.slave    bus
);

    typedef enum logic [1:0] {IDLE, STAMP, CLEAR, FIN} state_t;

    // Stamp parameters captured on acceptance; bx/by is the top-left corner.
    typedef struct packed {
        logic [10:0] bx;
        logic [10:0] by;
        logic [2:0]  side;   // 2r
        logic [2:0]  col;
    } stamp_t;

    state_t      state, state_d;
    stamp_t      lat, lat_d;
    logic [9:0]  cnt_x, cnt_y, cnt_x_d, cnt_y_d;
    logic        ready_q, ready_d;
    logic        brush_q, brush_d;
    logic        done_q, done_d;
    logic [9:0]  wx_q, wx_d, wy_q, wy_d;
    logic [2:0]  col_q, col_d;
    logic [10:0] px, py;
    logic        stamp_last, clear_last;

    // Coordinates are 11-bit two's complement; anything negative or past
    // the canvas edge is clipped.
    function automatic logic on_canvas(input logic [10:0] x, input logic [10:0] y);
        return !x[10] && !y[10] && (x < 11'(CANVAS_W)) && (y < 11'(CANVAS_H));
    endfunction

    assign stamp_last = (cnt_x == {7'd0, lat.side}) && (cnt_y == {7'd0, lat.side});
    assign clear_last = (cnt_x == 10'(CANVAS_W - 1)) && (cnt_y == 10'(CANVAS_H - 1));

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_d;
    end

    // next state; ready_q gates acceptance so nothing is taken on the
    // IDLE cycle straight out of reset
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (ready_q && bus.clear_req) state_d = CLEAR;
                     else if (ready_q && bus.req)  state_d = STAMP;
            STAMP:   if (stamp_last) state_d = FIN;
            CLEAR:   if (clear_last) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: next values of the registered write port. The counters always
    // hold the offset of the pixel currently on the outputs, so each cycle
    // computes the following pixel; on acceptance the first pixel is formed
    // straight from the inputs so it shows the very next cycle.
    always_comb begin
        lat_d   = lat;
        cnt_x_d = cnt_x;
        cnt_y_d = cnt_y;
        brush_d = 1'b0;
        done_d  = 1'b0;
        wx_d    = wx_q;
        wy_d    = wy_q;
        col_d   = col_q;
        px      = '0;
        py      = '0;
        case (state)
            IDLE: begin
                if (ready_q && bus.clear_req) begin
                    cnt_x_d = '0;
                    cnt_y_d = '0;
                    brush_d = 1'b1;
                    wx_d    = '0;
                    wy_d    = '0;
                    col_d   = CLEAR_COLOR;
                end else if (ready_q && bus.req) begin
                    lat_d.bx   = {1'b0, bus.cx} - {9'd0, bus.radius};
                    lat_d.by   = {1'b0, bus.cy} - {9'd0, bus.radius};
                    lat_d.side = {bus.radius, 1'b0};
                    lat_d.col  = bus.color;
                    cnt_x_d    = '0;
                    cnt_y_d    = '0;
                    px         = lat_d.bx;
                    py         = lat_d.by;
                    brush_d    = on_canvas(px, py);
                    if (brush_d) begin
                        wx_d  = px[9:0];
                        wy_d  = py[9:0];
                        col_d = bus.color;
                    end
                end
            end
            STAMP: begin
                if (stamp_last) begin
                    done_d = 1'b1;
                end else begin
                    if (cnt_x == {7'd0, lat.side}) begin
                        cnt_x_d = '0;
                        cnt_y_d = cnt_y + 10'd1;
                    end else begin
                        cnt_x_d = cnt_x + 10'd1;
                    end
                    px      = lat.bx + {1'b0, cnt_x_d};
                    py      = lat.by + {1'b0, cnt_y_d};
                    brush_d = on_canvas(px, py);
                    if (brush_d) begin
                        wx_d  = px[9:0];
                        wy_d  = py[9:0];
                        col_d = lat.col;
                    end
                end
            end
            CLEAR: begin
                if (clear_last) begin
                    done_d = 1'b1;
                end else begin
                    if (cnt_x == 10'(CANVAS_W - 1)) begin
                        cnt_x_d = '0;
                        cnt_y_d = cnt_y + 10'd1;
                    end else begin
                        cnt_x_d = cnt_x + 10'd1;
                    end
                    brush_d = 1'b1;
                    wx_d    = cnt_x_d;
                    wy_d    = cnt_y_d;
                    col_d   = CLEAR_COLOR;
                end
            end
            default: ;
        endcase
    end

    assign ready_d = (state_d == IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lat     <= '0;
            cnt_x   <= '0;
            cnt_y   <= '0;
            ready_q <= 1'b0;
            brush_q <= 1'b0;
            done_q  <= 1'b0;
            wx_q    <= '0;
            wy_q    <= '0;
            col_q   <= '0;
        end else begin
            lat     <= lat_d;
            cnt_x   <= cnt_x_d;
            cnt_y   <= cnt_y_d;
            ready_q <= ready_d;
            brush_q <= brush_d;
            done_q  <= done_d;
            wx_q    <= wx_d;
            wy_q    <= wy_d;
            col_q   <= col_d;
        end
    end

    assign bus.ready    = ready_q;
    assign bus.brush    = brush_q;
    assign bus.done     = done_q;
    assign bus.wx       = wx_q;
    assign bus.wy       = wy_q;
    assign bus.newColor = col_q;

endmodule

// File: tb/tb_brush_stamper.sv
// Bench for brush_stamper: a queue-based model expands each accepted
// operation into its list of per-cycle outputs; a compare process checks
// every cycle. Directed cases pin the model with literal expectations,
// then a randomized phase exercises overlap, clipping and resets.
module tb_brush_stamper;
    localparam int         W   = 10;
    localparam int         H   = 10;
    localparam logic [2:0] CLR = 3'b000;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;

    brush_stamper_if bus();

    brush_stamper #(.CANVAS_W(W), .CANVAS_H(H), .CLEAR_COLOR(CLR)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {bit b; bit d; int x; int y; int c;} ent_t;
    ent_t q[$];
    bit   m_ready = 1'b0, m_brush = 1'b0, m_done = 1'b0;
    int   m_wx = 0, m_wy = 0, m_c = 0;

    function automatic bit in_canvas(input int x, input int y);
        return x >= 0 && x < W && y >= 0 && y < H;
    endfunction

    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            q.delete();
            m_ready = 0; m_brush = 0; m_done = 0;
            m_wx = 0; m_wy = 0; m_c = 0;
        end else begin
            if (q.size() == 0 && m_ready && (bus.clear_req || bus.req)) begin
                if (bus.clear_req) begin
                    for (int y = 0; y < H; y++)
                        for (int x = 0; x < W; x++)
                            q.push_back('{1'b1, 1'b0, x, y, int'(CLR)});
                end else begin
                    int r;
                    r = int'(bus.radius);
                    for (int dy = 0; dy <= 2 * r; dy++)
                        for (int dx = 0; dx <= 2 * r; dx++) begin
                            int x, y;
                            x = int'(bus.cx) - r + dx;
                            y = int'(bus.cy) - r + dy;
                            q.push_back('{in_canvas(x, y), 1'b0, x, y, int'(bus.color)});
                        end
                end
                q.push_back('{1'b0, 1'b1, 0, 0, 0});
            end
            if (q.size() > 0) begin
                m_ready = 0;
                m_brush = q[0].b;
                m_done  = q[0].d;
                if (q[0].b) begin
                    m_wx = q[0].x; m_wy = q[0].y; m_c = q[0].c;
                end
                void'(q.pop_front());
            end else begin
                m_ready = 1; m_brush = 0; m_done = 0;
            end
        end
    end

    // ---------------- compare + observation log ----------------
    typedef struct {int cyc; int x; int y; int c;} wr_t;
    wr_t wlog[$];
    int  cyc = 0, done_cnt = 0, busy_cnt = 0;

    initial forever begin
        @(negedge clk);
        cyc++;
        chk("ready",    int'(bus.ready),    int'(m_ready));
        chk("brush",    int'(bus.brush),    int'(m_brush));
        chk("done",     int'(bus.done),     int'(m_done));
        chk("wx",       int'(bus.wx),       m_wx);
        chk("wy",       int'(bus.wy),       m_wy);
        chk("newColor", int'(bus.newColor), m_c);
        if (bus.brush) wlog.push_back('{cyc, int'(bus.wx), int'(bus.wy), int'(bus.newColor)});
        if (bus.done) done_cnt++;
        if (!bus.ready) busy_cnt++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_ready();
        int n = 0;
        while (!bus.ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("ready_timeout", 0, 1);
    endtask

    task automatic clear_logs();
        wlog.delete();
        done_cnt = 0;
        busy_cnt = 0;
    endtask

    task automatic run_op(input bit c, input bit r, input int x, input int y,
                          input int rad, input int col);
        wait_ready();
        clear_logs();
        bus.clear_req = c;
        bus.req       = r;
        bus.cx        = 10'(x);
        bus.cy        = 10'(y);
        bus.radius    = 2'(rad);
        bus.color     = 3'(col);
        @(negedge clk);
        bus.req       = 1'b0;
        bus.clear_req = 1'b0;
        wait_ready();
    endtask

    initial begin
        bus.req = 0; bus.clear_req = 0; bus.cx = 0; bus.cy = 0;
        bus.radius = 0; bus.color = 0;
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", int'(bus.ready), 0);
        chk("rst_brush", int'(bus.brush), 0);
        chk("rst_done",  int'(bus.done), 0);
        chk("rst_wx",    int'(bus.wx), 0);
        chk("rst_color", int'(bus.newColor), 0);
        #2 reset_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_reset", int'(bus.ready), 1);
        @(negedge clk);

        // interior stamp
        run_op(0, 1, 5, 5, 1, 5);
        chk("int_writes", wlog.size(), 9);
        if (wlog.size() == 9) begin
            chk("int_first_x", wlog[0].x, 4);
            chk("int_first_y", wlog[0].y, 4);
            chk("int_second_x", wlog[1].x, 5);
            chk("int_last_x",  wlog[8].x, 6);
            chk("int_last_y",  wlog[8].y, 6);
            chk("int_color",   wlog[4].c, 5);
            chk("int_span",    wlog[8].cyc - wlog[0].cyc, 8);
        end
        chk("int_done", done_cnt, 1);
        chk("int_busy", busy_cnt, 10);

        // corner clip
        run_op(0, 1, 0, 0, 1, 2);
        chk("corner_writes", wlog.size(), 4);
        if (wlog.size() == 4) begin
            chk("corner_w0", wlog[0].x * 100 + wlog[0].y, 0);
            chk("corner_w1", wlog[1].x * 100 + wlog[1].y, 100);
            chk("corner_w2", wlog[2].x * 100 + wlog[2].y, 1);
            chk("corner_w3", wlog[3].x * 100 + wlog[3].y, 101);
        end
        chk("corner_busy", busy_cnt, 10);
        chk("corner_done", done_cnt, 1);

        // fully off-canvas
        run_op(0, 1, 20, 20, 2, 7);
        chk("off_writes", wlog.size(), 0);
        chk("off_busy",   busy_cnt, 26);
        chk("off_done",   done_cnt, 1);

        // clear wins over stamp
        run_op(1, 1, 5, 5, 1, 5);
        chk("clr_writes", wlog.size(), 100);
        if (wlog.size() == 100) begin
            chk("clr_w0",    wlog[0].x * 100 + wlog[0].y, 0);
            chk("clr_w10",   wlog[10].x * 100 + wlog[10].y, 1);
            chk("clr_last",  wlog[99].x * 100 + wlog[99].y, 909);
            chk("clr_color", wlog[57].c, 0);
        end
        chk("clr_busy", busy_cnt, 101);

        // back-to-back r=0 stamps with req held through FIN
        wait_ready();
        clear_logs();
        bus.req = 1; bus.cx = 3; bus.cy = 3; bus.radius = 0; bus.color = 6;
        repeat (4) @(negedge clk);
        bus.req = 0;
        wait_ready();
        chk("b2b_writes", wlog.size(), 2);
        if (wlog.size() == 2) chk("b2b_gap", wlog[1].cyc - wlog[0].cyc, 3);
        chk("b2b_done", done_cnt, 2);

        // reset during write 3 of a radius-1 stamp
        wait_ready();
        clear_logs();
        bus.req = 1; bus.cx = 5; bus.cy = 5; bus.radius = 1; bus.color = 3;
        @(negedge clk);
        bus.req = 0;
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_brush", int'(bus.brush), 0);
        chk("midrst_ready", int'(bus.ready), 0);
        chk("midrst_wx",    int'(bus.wx), 0);
        @(negedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk); #1;
        chk("midrst_ready_after", int'(bus.ready), 1);
        repeat (10) @(negedge clk);
        chk("midrst_writes", wlog.size(), 3);
        chk("midrst_no_done", done_cnt, 0);

        // randomized traffic, occasional async reset pulse
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            bus.req       = ($urandom_range(0, 2) == 0);
            bus.clear_req = ($urandom_range(0, 79) == 0);
            bus.cx     = ($urandom_range(0, 4) == 0) ? 10'($urandom_range(0, 1023))
                                                     : 10'($urandom_range(0, 13));
            bus.cy     = ($urandom_range(0, 4) == 0) ? 10'($urandom_range(0, 1023))
                                                     : 10'($urandom_range(0, 13));
            bus.radius = 2'($urandom_range(0, 3));
            bus.color  = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 799) == 0) begin
                #2 reset_n = 1'b0;
                #2 reset_n = 1'b1;
            end
        end
        @(negedge clk);
        bus.req = 0; bus.clear_req = 0;
        wait_ready();
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/brush_stamper.md
BRUSH_STAMPER -- requirements
Module: brush_stamper

Interface
REQ-001 Parameter CANVAS_W, default 10, canvas width in pixels.
REQ-002 Parameter CANVAS_H, default 10, canvas height in pixels.
REQ-003 Parameter CLEAR_COLOR, default 3'b000, colour written by a clear sweep.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  reset, asynchronous and active-low.
REQ-006 req  input  1  stamp request; qualified by ready.
REQ-007 clear_req  input  1  whole-canvas clear request; qualified by ready.
REQ-008 cx, cy  input  10 each  brush centre, unsigned pixel coordinates.
REQ-009 radius  input  2  brush radius r; square side is 2r+1.
REQ-010 color  input  3  colour code to paint.
REQ-011 ready  output  1  high only in IDLE; a request is accepted only when ready is high.
REQ-012 brush  output  1  pixel write strobe to the downstream pixel store.
REQ-013 wx, wy  output  10 each  write coordinates, valid when brush is high.
REQ-014 newColor  output  3  write colour, valid when brush is high.
REQ-015 done  output  1  one-cycle pulse when an operation completes.

Function
REQ-016 The block SHALL implement a state machine with states IDLE, STAMP, CLEAR and FIN.
REQ-017 In IDLE with clear_req high, the block SHALL enter CLEAR; clear_req SHALL take priority over req in the same cycle.
REQ-018 In IDLE with req high and clear_req low, the block SHALL latch cx, cy, radius and color, and enter STAMP.
REQ-019 After acceptance, request inputs SHALL be ignored until the block returns to IDLE.
REQ-020 STAMP SHALL visit offsets dx, dy in 0..2r in raster order, dx fastest, one offset per cycle, taking exactly (2r+1)^2 cycles.
REQ-021 The visited pixel SHALL be (cx-r+dx, cy-r+dy), computed in 11-bit signed arithmetic.
REQ-022 brush SHALL be high for a visited pixel only if 0 <= x < CANVAS_W and 0 <= y < CANVAS_H.
REQ-023 For a clipped pixel, brush SHALL be low while the cycle is still consumed.
REQ-024 CLEAR SHALL visit every pixel (0,0)..(CANVAS_W-1, CANVAS_H-1) in raster order, x fastest, one per cycle, with brush high and newColor = CLEAR_COLOR.
REQ-025 brush, wx, wy and newColor SHALL be registered.
REQ-026 The first write SHALL appear on the cycle after acceptance.
REQ-027 wx, wy and newColor SHALL hold their last values while brush is low.
REQ-028 After the final visited pixel, the block SHALL enter FIN for exactly one cycle with done high and brush low, then return to IDLE.
REQ-029 ready SHALL be high again on the cycle after FIN.
REQ-030 Back-to-back operation SHALL be supported: a request held high during FIN is accepted in the following IDLE cycle.
REQ-031 With r = 0, a stamp SHALL take one write cycle plus FIN.
REQ-032 A fully off-canvas stamp SHALL still take (2r+1)^2 cycles with no brush pulse, then assert done.

Reset
REQ-033 On reset_n low, the block SHALL asynchronously enter IDLE and clear all counters.
REQ-034 While reset_n is low, outputs SHALL be: ready=0, brush=0, done=0, wx=0, wy=0, newColor=0.
REQ-035 On the first clock edge after reset_n deasserts, ready SHALL be 1.
REQ-036 Reset asserted mid-STAMP or mid-CLEAR SHALL abort the operation immediately, with no further brush pulses and no done pulse.

Verification
REQ-037 Interior stamp: cx=5, cy=5, r=1, color=3'b101 -> 9 consecutive brush pulses (4,4),(5,4),(6,4),(4,5),...,(6,6), all newColor=5, then done one cycle later.
REQ-038 Corner clip: cx=0, cy=0, r=1 -> 9 cycles, brush high only at (0,0),(1,0),(0,1),(1,1), then done.
REQ-039 Off-canvas stamp: cx=20, cy=20, r=2 -> 25 cycles with brush low throughout, then done; ready=0 for 26 cycles.
REQ-040 Clear priority: req and clear_req both high in IDLE -> 100 writes (0,0)..(9,9) with newColor=0, then done.
REQ-041 Mid-operation reset: reset_n pulsed low during write 3 of a radius-1 stamp -> brush=0 at once, no done pulse, ready=1 one cycle after release.
REQ-042 Back-to-back: two r=0 stamps requested on consecutive ready windows -> writes exactly 3 cycles apart, with two done pulses.
